// File: rtl/instr_pingpong_buf_if.sv
// Loader/decoder handshake bundle for the N-way instruction block buffer.
// Ports: flush, wr_vld/wr_data/wr_last, rd_rdy driven by the master (loader + decoder side);
//        wr_rdy, rd_vld/rd_data/rd_last, rd_buf_id, full_cnt, err_ovf driven by the slave (buffer).
interface instr_pingpong_buf_if #(
  parameter int WORD_L = 32,
  parameter int N_BUF  = 2,
  parameter int ID_L   = $clog2(N_BUF)
);
  logic              flush;
  logic              wr_vld;
  logic [WORD_L-1:0] wr_data;
  logic              wr_last;
  logic              wr_rdy;
  logic              rd_rdy;
  logic              rd_vld;
  logic [WORD_L-1:0] rd_data;
  logic              rd_last;
  logic [ID_L-1:0]   rd_buf_id;
  logic [ID_L:0]     full_cnt;
  logic              err_ovf;

  modport master (
    output flush, wr_vld, wr_data, wr_last, rd_rdy,
    input  wr_rdy, rd_vld, rd_data, rd_last, rd_buf_id, full_cnt, err_ovf
  );

  modport slave (
    input  flush, wr_vld, wr_data, wr_last, rd_rdy,
    output wr_rdy, rd_vld, rd_data, rd_last, rd_buf_id, full_cnt, err_ovf
  );
endinterface

// File: rtl/instr_pingpong_buf.sv
// N_BUF-bank round-robin instruction block buffer between memory loader and tree decoder.
// Latency: a closed block is readable the cycle after its closing word; read data is combinational.
// Backpressure: wr_rdy drops while the write bank is still FULL; rd_vld only while the read bank is FULL.
// Ports: clk, rst (async, active-high); bus = slave side of instr_pingpong_buf_if (loader writes,
//        decoder reads, flush, block-length/bank status and sticky overflow flag).
module instr_pingpong_buf #(
  parameter  int WORD_L = 32,
  parameter  int DEPTH  = 64,
  parameter  int N_BUF  = 2,
  localparam int CNT_L  = $clog2(DEPTH + 1),
  localparam int ID_L   = $clog2(N_BUF)
) (
  input  logic                 clk,
  input  logic                 rst,
  instr_pingpong_buf_if.slave  bus
);

  localparam int IDX_L = $clog2(DEPTH);
  localparam logic [ID_L:0] FC_ONE = 1;

  typedef enum logic [1:0] {EMPTY, FILLING, FULL} bank_st_e;

  bank_st_e          st_q  [N_BUF];
  bank_st_e          st_d  [N_BUF];
  logic [CNT_L-1:0]  len_q [N_BUF];
  logic [CNT_L-1:0]  len_d [N_BUF];
  logic [ID_L-1:0]   wp_q, wp_d, rp_q, rp_d;
  logic [IDX_L-1:0]  wi_q, wi_d, ri_q, ri_d;
  logic              err_ovf_q, err_ovf_d;
  logic [WORD_L-1:0] mem_q [N_BUF][DEPTH];

  logic              wr_rdy, rd_vld, rd_last, wr_fire, rd_fire, wr_close;
  logic [ID_L:0]     full_cnt;

  // Round-robin successor; N_BUF need not be a power of two.
  function automatic logic [ID_L-1:0] bump(input logic [ID_L-1:0] p);
    return (p == ID_L'(N_BUF - 1)) ? '0 : p + ID_L'(1);
  endfunction

  // Writer and reader can never share a bank: the write bank is never FULL
  // while accepting, and the read bank is only served while FULL.
  always_comb begin
    wr_rdy   = (st_q[wp_q] != FULL);
    rd_vld   = (st_q[rp_q] == FULL);
    rd_last  = rd_vld && (CNT_L'(ri_q) == len_q[rp_q] - CNT_L'(1));
    wr_fire  = bus.wr_vld && wr_rdy;
    rd_fire  = rd_vld && bus.rd_rdy;
    wr_close = bus.wr_last || (wi_q == IDX_L'(DEPTH - 1));
    full_cnt = '0;
    for (int b = 0; b < N_BUF; b++) begin
      if (st_q[b] == FULL) full_cnt = full_cnt + FC_ONE;
    end
  end

  assign bus.wr_rdy    = wr_rdy;
  assign bus.rd_vld    = rd_vld;
  assign bus.rd_last   = rd_last;
  assign bus.rd_data   = rd_vld ? mem_q[rp_q][ri_q] : '0;
  assign bus.rd_buf_id = rp_q;
  assign bus.full_cnt  = full_cnt;
  assign bus.err_ovf   = err_ovf_q;

  always_comb begin
    st_d      = st_q;
    len_d     = len_q;
    wp_d      = wp_q;
    wi_d      = wi_q;
    rp_d      = rp_q;
    ri_d      = ri_q;
    err_ovf_d = err_ovf_q;
    if (bus.flush) begin
      for (int b = 0; b < N_BUF; b++) st_d[b] = EMPTY;
      wp_d      = '0;
      wi_d      = '0;
      rp_d      = '0;
      ri_d      = '0;
      err_ovf_d = 1'b0;
    end else begin
      if (wr_fire) begin
        wi_d        = wi_q + IDX_L'(1);
        st_d[wp_q]  = FILLING;
        if (wr_close) begin
          st_d[wp_q]  = FULL;
          len_d[wp_q] = CNT_L'(wi_q) + CNT_L'(1);
          wi_d        = '0;
          wp_d        = bump(wp_q);
          // Bank ran out of room before the loader marked the block end.
          if (!bus.wr_last) err_ovf_d = 1'b1;
        end
      end
      if (rd_fire) begin
        ri_d = ri_q + IDX_L'(1);
        if (rd_last) begin
          st_d[rp_q] = EMPTY;
          ri_d       = '0;
          rp_d       = bump(rp_q);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int b = 0; b < N_BUF; b++) begin
        st_q[b]  <= EMPTY;
        len_q[b] <= '0;
      end
      wp_q      <= '0;
      wi_q      <= '0;
      rp_q      <= '0;
      ri_q      <= '0;
      err_ovf_q <= 1'b0;
    end else begin
      st_q      <= st_d;
      len_q     <= len_d;
      wp_q      <= wp_d;
      wi_q      <= wi_d;
      rp_q      <= rp_d;
      ri_q      <= ri_d;
      err_ovf_q <= err_ovf_d;
    end
  end

  // Word storage is deliberately unreset; rd_data is masked while !rd_vld.
  always_ff @(posedge clk) begin
    if (wr_fire && !bus.flush) mem_q[wp_q][wi_q] <= bus.wr_data;
  end

endmodule

// File: tb/tb_instr_pingpong_buf.sv
module tb_instr_pingpong_buf;
  localparam int WL = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  instr_pingpong_buf_if #(.WORD_L(WL), .N_BUF(2)) if_a ();
  instr_pingpong_buf_if #(.WORD_L(WL), .N_BUF(3)) if_b ();

  instr_pingpong_buf #(.WORD_L(WL), .DEPTH(4), .N_BUF(2)) dut_a (.clk(clk), .rst(rst), .bus(if_a.slave));
  instr_pingpong_buf #(.WORD_L(WL), .DEPTH(8), .N_BUF(3)) dut_b (.clk(clk), .rst(rst), .bus(if_b.slave));

  typedef struct {
    string name;
    bit    fl, wv; int wd; bit wl, rr;
    bit    e_wrdy, e_rvld; int e_rd; bit e_rl; int e_id; int e_fc; bit e_err;
  } vec_t;
  vec_t vt[$];

  typedef struct { logic [31:0] d; logic l; int id; } sb_t;
  sb_t sb[$];
  int  b_wbank = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add(input string n, input bit fl, input bit wv, input int wd, input bit wl, input bit rr,
                     input bit ewr, input bit erv, input int erd, input bit erl, input int eid,
                     input int efc, input bit eerr);
    vec_t v;
    v.name = n; v.fl = fl; v.wv = wv; v.wd = wd; v.wl = wl; v.rr = rr;
    v.e_wrdy = ewr; v.e_rvld = erv; v.e_rd = erd; v.e_rl = erl; v.e_id = eid; v.e_fc = efc; v.e_err = eerr;
    vt.push_back(v);
  endtask

  task automatic a_drive(input bit fl, input bit wv, input int wd, input bit wl, input bit rr);
    @(negedge clk);
    if_a.flush = fl; if_a.wr_vld = wv; if_a.wr_data = wd; if_a.wr_last = wl; if_a.rd_rdy = rr;
  endtask

  task automatic a_expect(input string n, input bit wrdy, input bit rvld, input int rd, input bit rl,
                          input int id, input int fc, input bit err);
    chk({n, " wr_rdy"},    32'(if_a.wr_rdy),    32'(wrdy));
    chk({n, " rd_vld"},    32'(if_a.rd_vld),    32'(rvld));
    chk({n, " rd_data"},   if_a.rd_data,        rd);
    chk({n, " rd_last"},   32'(if_a.rd_last),   32'(rl));
    chk({n, " rd_buf_id"}, 32'(if_a.rd_buf_id), id);
    chk({n, " full_cnt"},  32'(if_a.full_cnt),  fc);
    chk({n, " err_ovf"},   32'(if_a.err_ovf),   32'(err));
  endtask

  // Streams n words in blocks of blk into DUT B; every accepted word is queued with
  // the bank it went to and checked when the decoder side accepts it.
  task automatic stream(input string name, input int n, input int blk, input bit rand_rd,
                        input int base, input bit want_overlap);
    int  sent = 0, got = 0, cyc = 0, max_fc = 0, overlap = 0;
    bit  wf, rf, rl;
    sb_t e;
    while (got < n) begin
      @(negedge clk);
      if_b.wr_vld  = (sent < n);
      if_b.wr_data = base + sent;
      if_b.wr_last = ((sent % blk) == blk - 1) || (sent == n - 1);
      if_b.rd_rdy  = rand_rd ? ($urandom_range(0, 3) != 0) : 1'b1;
      #1;
      if (int'(if_b.full_cnt) > max_fc) max_fc = int'(if_b.full_cnt);
      wf = if_b.wr_vld && if_b.wr_rdy;
      rf = if_b.rd_vld && if_b.rd_rdy;
      rl = if_b.rd_last;
      if (rf) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL %s unexpected read: got 0x%0h expected no word", name, if_b.rd_data);
        end else begin
          e = sb.pop_front();
          chk({name, " data"},   if_b.rd_data,        e.d);
          chk({name, " last"},   32'(if_b.rd_last),   32'(e.l));
          chk({name, " buf_id"}, 32'(if_b.rd_buf_id), e.id);
        end
        got++;
      end
      if (wf) begin
        e.d = if_b.wr_data; e.l = if_b.wr_last; e.id = b_wbank;
        sb.push_back(e);
        sent++;
        if (if_b.wr_last) b_wbank = (b_wbank + 1) % 3;
      end
      if (wf && rf && rl) overlap++;
      cyc++;
      if (cyc > 2000) begin
        checks++; errors++;
        $display("FAIL %s timeout: got %0d words expected %0d", name, got, n);
        break;
      end
    end
    @(negedge clk);
    if_b.wr_vld = 1'b0; if_b.wr_last = 1'b0; if_b.rd_rdy = 1'b0;
    #1;
    chk({name, " full_cnt<=N_BUF"}, 32'(max_fc <= 3), 32'd1);
    chk({name, " leftover"},       32'(sb.size()),   32'd0);
    chk({name, " err_ovf"},        32'(if_b.err_ovf), 32'd0);
    if (want_overlap) chk({name, " same-cycle free+close"}, 32'(overlap > 0), 32'd1);
  endtask

  initial begin
    if_a.flush = 0; if_a.wr_vld = 0; if_a.wr_data = 0; if_a.wr_last = 0; if_a.rd_rdy = 0;
    if_b.flush = 0; if_b.wr_vld = 0; if_b.wr_data = 0; if_b.wr_last = 0; if_b.rd_rdy = 0;

    //   name            fl wv data  wl rr | wrdy rvld rd   rl id fc err
    add("rst_idle",      0, 0, 0,    0, 0,   1,   0,   0,    0, 0, 0, 0);
    add("wr_a0",         0, 1, 'hA0, 0, 0,   1,   0,   0,    0, 0, 0, 0);
    add("wr_a1",         0, 1, 'hA1, 1, 0,   1,   0,   0,    0, 0, 0, 0);
    add("a_visible",     0, 0, 0,    0, 0,   1,   1,   'hA0, 0, 0, 1, 0);
    add("rd_a0",         0, 0, 0,    0, 1,   1,   1,   'hA0, 0, 0, 1, 0);
    add("rd_a1",         0, 0, 0,    0, 1,   1,   1,   'hA1, 1, 0, 1, 0);
    add("a_done",        0, 0, 0,    0, 0,   1,   0,   0,    0, 1, 0, 0);
    add("wr_b0",         0, 1, 'hB0, 0, 0,   1,   0,   0,    0, 1, 0, 0);
    add("wr_b1",         0, 1, 'hB1, 1, 0,   1,   0,   0,    0, 1, 0, 0);
    add("wr_c0",         0, 1, 'hC0, 1, 0,   1,   1,   'hB0, 0, 1, 1, 0);
    add("both_full",     0, 1, 'hEE, 0, 0,   0,   1,   'hB0, 0, 1, 2, 0);
    add("rd_b0_pulse",   0, 1, 'hEE, 0, 1,   0,   1,   'hB0, 0, 1, 2, 0);
    add("hold_b1",       0, 1, 'hEE, 0, 0,   0,   1,   'hB1, 1, 1, 2, 0);
    add("rd_b1",         0, 1, 'hEE, 0, 1,   0,   1,   'hB1, 1, 1, 2, 0);
    add("bank1_freed",   0, 0, 0,    0, 0,   1,   1,   'hC0, 1, 0, 1, 0);
    add("rd_c0_wr_d0",   0, 1, 'hD0, 0, 1,   1,   1,   'hC0, 1, 0, 1, 0);
    add("wr_d1",         0, 1, 'hD1, 0, 0,   1,   0,   0,    0, 1, 0, 0);
    add("wr_d2",         0, 1, 'hD2, 0, 0,   1,   0,   0,    0, 1, 0, 0);
    add("wr_d3_ovf",     0, 1, 'hD3, 0, 0,   1,   0,   0,    0, 1, 0, 0);
    add("d_visible",     0, 0, 0,    0, 0,   1,   1,   'hD0, 0, 1, 1, 1);
    add("rd_d0",         0, 0, 0,    0, 1,   1,   1,   'hD0, 0, 1, 1, 1);
    add("rd_d1",         0, 0, 0,    0, 1,   1,   1,   'hD1, 0, 1, 1, 1);
    add("rd_d2",         0, 0, 0,    0, 1,   1,   1,   'hD2, 0, 1, 1, 1);
    add("rd_d3",         0, 0, 0,    0, 1,   1,   1,   'hD3, 1, 1, 1, 1);
    add("err_sticky",    0, 0, 0,    0, 0,   1,   0,   0,    0, 0, 0, 1);
    add("flush",         1, 1, 'h99, 1, 1,   1,   0,   0,    0, 0, 0, 1);
    add("after_flush",   0, 0, 0,    0, 0,   1,   0,   0,    0, 0, 0, 0);

    repeat (2) @(negedge clk);
    rst = 1'b0;

    foreach (vt[i]) begin
      a_drive(vt[i].fl, vt[i].wv, vt[i].wd, vt[i].wl, vt[i].rr);
      #1;
      a_expect(vt[i].name, vt[i].e_wrdy, vt[i].e_rvld, vt[i].e_rd, vt[i].e_rl,
               vt[i].e_id, vt[i].e_fc, vt[i].e_err);
    end
    a_drive(0, 0, 0, 0, 0);

    // Scoreboarded streams on the three-bank instance.
    stream("one_word_blocks", 7,  1, 1'b0, 'h100, 1'b1);
    stream("blk8_stream",     32, 8, 1'b0, 'h200, 1'b1);
    stream("blk8_backpress",  40, 8, 1'b1, 'h300, 1'b0);
    stream("blk5_backpress",  30, 5, 1'b1, 'h400, 1'b0);

    // Async reset with bank0 FULL (overflowed) and bank1 mid-fill.
    for (int i = 0; i < 4; i++) a_drive(0, 1, 'h10 + i, 0, 0);
    a_drive(0, 1, 'h20, 0, 0);
    a_drive(0, 0, 0, 0, 0);
    #1;
    a_expect("pre_rst", 1, 1, 'h10, 0, 0, 1, 1);
    #2 rst = 1'b1;
    #1;
    a_expect("in_rst", 1, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    a_drive(0, 1, 'h30, 1, 0);
    a_drive(0, 0, 0, 0, 0);
    #1;
    a_expect("post_rst_blk", 1, 1, 'h30, 1, 0, 1, 0);
    a_drive(0, 0, 0, 0, 1);
    a_drive(0, 0, 0, 0, 0);

    // Same scenario via flush; pointers now sit at bank 1.
    for (int i = 0; i < 4; i++) a_drive(0, 1, 'h50 + i, 0, 0);
    a_drive(0, 1, 'h60, 0, 0);
    a_drive(1, 1, 'hEE, 1, 1);
    #1;
    a_expect("flush_cycle", 1, 1, 'h50, 0, 1, 1, 1);
    a_drive(0, 0, 0, 0, 0);
    #1;
    a_expect("post_flush", 1, 0, 0, 0, 0, 0, 0);
    a_drive(0, 1, 'h70, 1, 0);
    a_drive(0, 0, 0, 0, 0);
    #1;
    a_expect("post_flush_blk", 1, 1, 'h70, 1, 0, 1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
